// File: rtl/mips_pkg.sv
// Shared MIPS definitions: field positions, NOP, instruction overlay, IF/ID state.
// Used by if_id_stage and by later stages that slice instruction words.
package mips_pkg;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int TGT_MSB   = 25;
  localparam int TGT_LSB   = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } r_fmt_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
  } i_fmt_t;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [25:0] target;
  } j_fmt_t;

  typedef union packed {
    r_fmt_t r;
    i_fmt_t i;
    j_fmt_t j;
  } instr_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ifid_state_e;

endpackage

// File: rtl/instr_field_split.sv
// Combinational slicer from an instruction word to its R/I/J fields.
// Pure wiring; reused wherever a stage needs the decoded fields.
module instr_field_split
  import mips_pkg::*;
(
  input  instr_t      instr_i,
  output logic [5:0]  opcode_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [5:0]  funct_o,
  output logic [15:0] imm16_o,
  output logic [25:0] target_o
);

  assign opcode_o = instr_i.r.opcode;
  assign rs_o     = instr_i.r.rs;
  assign rt_o     = instr_i.r.rt;
  assign rd_o     = instr_i.r.rd;
  assign shamt_o  = instr_i.r.shamt;
  assign funct_o  = instr_i.r.funct;
  assign imm16_o  = instr_i.i.imm;
  assign target_o = instr_i.j.target;

endmodule

// File: rtl/if_id_stage.sv
// IF->ID pipeline register with valid/ready handshake and flush.
// Define IFID_SKID_EN for a skid slot and a registered in_ready.
module if_id_stage #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc4,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc4,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [15:0]     out_imm16,
  output logic [25:0]     out_target
);
  import mips_pkg::*;

  ifid_state_e     state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic            in_fire;
  logic            out_fire;

  assign out_valid = (state_q != EMPTY);

`ifdef IFID_SKID_EN
  logic [XLEN-1:0] sk_instr_q, sk_instr_d;
  logic [XLEN-1:0] sk_pc4_q, sk_pc4_d;

  // Depends only on registered state, so no path from out_ready.
  assign in_ready = rst_n && !flush && (state_q != TWO);
`else
  assign in_ready = rst_n && !flush
                    && (!out_valid || out_ready);
`endif

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready && !flush;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
`ifdef IFID_SKID_EN
    sk_instr_d = sk_instr_q;
    sk_pc4_d   = sk_pc4_q;
`endif
    if (flush) begin
      state_d = EMPTY;
      instr_d = NOP_INSTR;
      pc4_d   = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            instr_d = in_instr;
            pc4_d   = in_pc4;
          end
        end
        ONE: begin
          if (out_fire && in_fire) begin
            instr_d = in_instr;
            pc4_d   = in_pc4;
          end else if (out_fire) begin
            state_d = EMPTY;
            instr_d = NOP_INSTR;
            pc4_d   = '0;
`ifdef IFID_SKID_EN
          end else if (in_fire) begin
            state_d    = TWO;
            sk_instr_d = in_instr;
            sk_pc4_d   = in_pc4;
`endif
          end
        end
`ifdef IFID_SKID_EN
        TWO: begin
          if (out_fire) begin
            state_d = ONE;
            instr_d = sk_instr_q;
            pc4_d   = sk_pc4_q;
          end
        end
`endif
        default: begin
          state_d = EMPTY;
          instr_d = NOP_INSTR;
          pc4_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
`ifdef IFID_SKID_EN
      sk_instr_q <= '0;
      sk_pc4_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
`ifdef IFID_SKID_EN
      sk_instr_q <= sk_instr_d;
      sk_pc4_q   <= sk_pc4_d;
`endif
    end
  end

  assign out_instr = instr_q;
  assign out_pc4   = pc4_q;

  instr_field_split u_split (
    .instr_i  (instr_t'(instr_q)),
    .opcode_o (out_opcode),
    .rs_o     (out_rs),
    .rt_o     (out_rt),
    .rd_o     (out_rd),
    .shamt_o  (out_shamt),
    .funct_o  (out_funct),
    .imm16_o  (out_imm16),
    .target_o (out_target)
  );

endmodule

// File: tb/tb_if_id_stage.sv
// Directed self-checking bench for if_id_stage (either build of IFID_SKID_EN).
// Expected values are hand-computed constants.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc4 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [4:0]  out_shamt;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;
  logic [25:0] out_target;

  int n_chk = 0;
  int n_pass = 0;
  int acc;

`ifdef IFID_SKID_EN
  localparam int EXP_ACC = 2;
`else
  localparam int EXP_ACC = 1;
`endif

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc4     (in_pc4),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_pc4    (out_pc4),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_shamt  (out_shamt),
    .out_funct  (out_funct),
    .out_imm16  (out_imm16),
    .out_target (out_target)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] i,
                       input logic [31:0] p);
    in_valid = 1'b1;
    in_instr = i;
    in_pc4   = p;
    #1;
  endtask

  task automatic fill(output int n, input int base);
    logic take;
    n = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      offer(32'hC000_0000 + base + n, 32'h200 + 4 * (base + n));
      take = in_ready;
      tick();
      if (take) n++;
    end
    in_valid = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, 0);
    check("rst_pc4", out_pc4, 0);
    check("rst_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_instr", out_instr, 0);

    out_ready = 1'b1;
    offer(32'h2128_A4AA, 32'h0000_0004);
    tick();
    in_valid = 1'b0;
    check("one_valid", out_valid, 1);
    check("one_instr", out_instr, 32'h2128_A4AA);
    check("one_pc4", out_pc4, 32'h4);
    check("one_opcode", out_opcode, 32'h08);
    check("one_rs", out_rs, 9);
    check("one_rt", out_rt, 8);
    check("one_rd", out_rd, 20);
    check("one_shamt", out_shamt, 18);
    check("one_funct", out_funct, 32'h2A);
    check("one_imm16", out_imm16, 32'hA4AA);
    check("one_target", out_target, 32'h0128_A4AA);
    tick();
    check("one_drain_valid", out_valid, 0);
    check("one_drain_instr", out_instr, 0);

    for (int i = 0; i < 8; i++) begin
      offer(32'h8C00_0100 + i, 32'h1000 + 4 * (i + 1));
      check("b2b_ready", in_ready, 1);
      tick();
      check("b2b_valid", out_valid, 1);
      check("b2b_instr", out_instr, 32'h8C00_0100 + i);
      check("b2b_pc4", out_pc4, 32'h1000 + 4 * (i + 1));
    end
    in_valid = 1'b0;
    tick();
    check("b2b_empty", out_valid, 0);
    check("b2b_nop", out_instr, 0);

    fill(acc, 0);
    check("stall_acc", acc, EXP_ACC);
    check("stall_ready", in_ready, 0);
    check("stall_valid", out_valid, 1);
    check("stall_head", out_instr, 32'hC000_0000);
    check("stall_head_pc4", out_pc4, 32'h200);
    out_ready = 1'b1;
    tick();
`ifdef IFID_SKID_EN
    check("drain_valid", out_valid, 1);
    check("drain_instr", out_instr, 32'hC000_0001);
    check("drain_pc4", out_pc4, 32'h204);
    tick();
`endif
    check("drain_empty", out_valid, 0);
    check("drain_nop", out_instr, 0);

    fill(acc, 16);
    check("pre_flush_acc", acc, EXP_ACC);
    offer(32'hF00D_0001, 32'h300);
    flush = 1'b1;
    #1;
    check("flush_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_valid", out_valid, 0);
    check("flush_instr", out_instr, 0);
    check("flush_after_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("refill_valid", out_valid, 1);
    check("refill_instr", out_instr, 32'hF00D_0001);
    check("refill_pc4", out_pc4, 32'h300);
    out_ready = 1'b1;
    tick();
    check("refill_empty", out_valid, 0);

    fill(acc, 32);
    check("pre_rst_acc", acc, EXP_ACC);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_instr", out_instr, 0);
    check("midrst_pc4", out_pc4, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("midrst_no_stale", out_valid, 0);
      check("midrst_nop", out_instr, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
